// File: rtl/fib_datapath.sv
// Datapath for an iterative Fibonacci engine driven by an external controller.
// Holds the operand pair, running sum, iteration counter and the registered result.
module fib_datapath #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_regs,
    input  logic             add_regs,
    input  logic             shift_regs,
    input  logic             decr_c,
    input  logic             ready,
    input  logic [CNT_W-1:0] n_in,
    output logic             zero,
    output logic [WIDTH-1:0] fib_out,
    output logic             overflow,
    output logic             result_valid
);

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] s_reg;
    logic             a_ovf;
    logic             b_ovf;
    logic             s_ovf;
    logic [CNT_W-1:0] c_reg;
    logic             busy;
    logic             ready_q;
    logic [WIDTH:0]   sum_full;
    logic             done;

    assign sum_full = {1'b0, a_reg} + {1'b0, b_reg};
    assign zero     = (c_reg == '0);
    assign done     = ready & ~ready_q & busy;

    // Overflow flags travel with their operands so a truncated term stays marked
    // through every later add and shift; shift always sees the pre-edge sum.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            a_reg <= '0;
            b_reg <= WIDTH'(1);
            s_reg <= '0;
            a_ovf <= 1'b0;
            b_ovf <= 1'b0;
            s_ovf <= 1'b0;
        end else if (load_regs) begin
            a_reg <= '0;
            b_reg <= WIDTH'(1);
            s_reg <= '0;
            a_ovf <= 1'b0;
            b_ovf <= 1'b0;
            s_ovf <= 1'b0;
        end else begin
            if (add_regs) begin
                s_reg <= sum_full[WIDTH-1:0];
                s_ovf <= sum_full[WIDTH] | a_ovf | b_ovf;
            end
            if (shift_regs) begin
                a_reg <= b_reg;
                b_reg <= s_reg;
                a_ovf <= b_ovf;
                b_ovf <= s_ovf;
            end
        end
    end

    // Counter saturates at zero so n_in = 0 still ends after one iteration.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            c_reg <= '0;
        end else if (load_regs) begin
            c_reg <= n_in;
        end else if (decr_c && (c_reg != '0)) begin
            c_reg <= c_reg - CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy    <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            ready_q <= ready;
            if (load_regs) begin
                busy <= 1'b1;
            end else if (done) begin
                busy <= 1'b0;
            end
        end
    end

    // A result is published only on a ready rise that ends a loaded job.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fib_out      <= '0;
            overflow     <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= done;
            if (done) begin
                fib_out  <= a_reg;
                overflow <= a_ovf;
            end
        end
    end

endmodule

// File: doc/fib_datapath.md
FIB_DATAPATH -- requirements
Module: fib_datapath

Interface
REQ-001 Parameter WIDTH, default 16: width of the Fibonacci operand and result registers.
REQ-002 Parameter CNT_W, default 5: width of the iteration counter and of n_in.
REQ-003 clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; low clears all state immediately, regardless of clock.
REQ-005 load_regs  input  1  controller strobe: initialise operands and latch n_in.
REQ-006 add_regs  input  1  controller strobe: compute the next term into the sum register.
REQ-007 shift_regs  input  1  controller strobe: advance the operand pair.
REQ-008 decr_c  input  1  controller strobe: decrement the iteration counter.
REQ-009 ready  input  1  controller idle indication; used for completion detection.
REQ-010 n_in  input  CNT_W  requested term index, sampled only on load_regs.
REQ-011 zero  output  1  combinational; high when counter C equals 0.
REQ-012 fib_out  output  WIDTH  registered result, F(n) modulo 2^WIDTH.
REQ-013 overflow  output  1  registered; high when fib_out was truncated.
REQ-014 result_valid  output  1  registered single-cycle pulse marking a new fib_out.

Function
REQ-015 Internal state: A, B, S (WIDTH bits each); flags a_ovf, b_ovf, s_ovf; counter C (CNT_W bits); flag busy; registered copy ready_q of ready.
REQ-016 load_regs: A<=0, B<=1, S<=0, C<=n_in, all ovf flags<=0, busy<=1; it has highest priority, and add/shift/decr in the same cycle are ignored.
REQ-017 add_regs: {carry,S}<=A+B computed at WIDTH+1 bits; s_ovf<=carry|a_ovf|b_ovf.
REQ-018 shift_regs: A<=B, B<=S, a_ovf<=b_ovf, b_ovf<=s_ovf; all use pre-edge values.
REQ-019 add_regs and shift_regs in the same cycle: both take effect, and shift uses the pre-edge S (the new sum is not forwarded).
REQ-020 decr_c: C<=C-1 when C!=0; C holds at 0 (no wrap to all-ones).
REQ-021 decr_c is independent of add/shift and may coincide with either.
REQ-022 Completion: when ready is high, ready_q is low and busy is high, on that edge fib_out<=A, overflow<=a_ovf, result_valid<=1 and busy<=0.
REQ-023 result_valid is low in every other cycle; fib_out and overflow hold until the next completion.
REQ-024 A ready rise with busy low (e.g. first cycle after reset) produces no result_valid.
REQ-025 With the standard controller sequence (load, then {add; shift+decr; check} per iteration until zero), fib_out=F(n_in) for n_in>=1.
REQ-026 n_in=0: the controller executes one iteration before checking zero, and C saturates per REQ-020, so fib_out=1 (F(1)); this is defined behaviour, not an error.
REQ-027 zero is derived only from C and has no dependence on strobes in the same cycle.

Reset
REQ-028 reset low: A=0, B=1, S=0, C=0, all ovf flags=0, busy=0, ready_q=0, fib_out=0, overflow=0, result_valid=0; consequently zero=1.
REQ-029 Reset asserted mid-computation aborts it with no result_valid pulse; after release, the block waits for load_regs.
REQ-030 Reset deassertion is synchronised to clock by the integrating top level; this block adds no synchroniser.

Verification
REQ-031 n_in=5 via full controller sequence -> single result_valid pulse as ready rises, fib_out=5, overflow=0.
REQ-032 n_in=10 -> fib_out=55; n_in=24 (WIDTH=16) -> fib_out=46368, overflow=0.
REQ-033 n_in=25 (WIDTH=16) -> fib_out=9489 (75025 mod 65536), overflow=1; next load with n_in=3 -> fib_out=2, overflow=0.
REQ-034 n_in=0 -> fib_out=1, zero=1 immediately after load, and C never reads all-ones.
REQ-035 Direct strobes: load_regs with add_regs+shift_regs in the same cycle -> A=0, B=1, S=0; then add+shift together -> A=1, B=0 (pre-edge S), S=1.
REQ-036 reset pulsed low during iteration 3 of n_in=8 -> all outputs at reset values, no result_valid; a fresh n_in=8 run -> fib_out=21.
